// File: rtl/ski_mem_pkg.sv
// rtl/ski_mem_pkg.sv - shared status codes, state enum and default parameters for the SKI term store
package ski_mem_pkg;

  localparam int NCH_DEF            = 2;
  localparam int AW_DEF             = 30;
  localparam int DW_DEF             = 64;
  localparam int DEPTH_DEF          = 1024;
  localparam int CLEAR_ON_RESET_DEF = 1;

  typedef enum logic [1:0] {
    RSP_NONE = 2'b00,
    RSP_READ = 2'b01,
    RSP_WACK = 2'b10,
    RSP_AERR = 2'b11
  } rsp_status_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ski_rr_arbiter.sv
// rtl/ski_rr_arbiter.sv - round-robin arbiter: picks the first requester at or after ptr, wrapping
module ski_rr_arbiter #(
  parameter  int NCH = 2,
  localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [PW-1:0]  idx
);

  int c;

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    c     = 0;
    for (int off = NCH - 1; off >= 0; off--) begin
      c = (int'(ptr) + off) % NCH;
      if (req[c]) begin
        grant    = '0;
        grant[c] = 1'b1;
        idx      = PW'(c);
      end
    end
  end

endmodule

// File: rtl/ski_mem_ctrl.sv
// rtl/ski_mem_ctrl.sv - multi-channel SKI term memory with round-robin access and optional zero-fill
module ski_mem_ctrl
  import ski_mem_pkg::*;
#(
  parameter int NCH            = NCH_DEF,
  parameter int AW             = AW_DEF,
  parameter int DW             = DW_DEF,
  parameter int DEPTH          = DEPTH_DEF,
  parameter int CLEAR_ON_RESET = CLEAR_ON_RESET_DEF
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH-1:0]    req_we,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*DW-1:0] req_wdata,
  output logic [NCH-1:0]    req_ready,
  output logic [NCH*2-1:0]  rsp_status,
  output logic [NCH*DW-1:0] rsp_data,
  output logic              busy
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e         state, state_nxt;
  logic [MW-1:0]  init_cnt;
  logic [PW-1:0]  rr_ptr, gnt_idx;
  logic [NCH-1:0] gnt;
  logic [DW-1:0]  mem [DEPTH];

  logic           xfer, sel_we, in_range;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic [MW-1:0]  mem_idx;

  ski_rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_cnt == MW'(DEPTH - 1)) state_nxt = ST_RUN;
  end

  always_comb begin
    busy      = (state == ST_INIT);
    req_ready = (state == ST_RUN && !system1000_rst) ? gnt : '0;
  end

  // Full-width compare so high pointer bits cannot alias into the array.
  always_comb begin
    xfer      = |req_ready;
    sel_addr  = req_addr[gnt_idx*AW +: AW];
    sel_wdata = req_wdata[gnt_idx*DW +: DW];
    sel_we    = req_we[gnt_idx];
    in_range  = (64'(sel_addr) < 64'(DEPTH));
    mem_idx   = sel_addr[MW-1:0];
  end

  always_ff @(posedge system1000) begin
    if (!system1000_rst) begin
      if (state == ST_INIT)                   mem[init_cnt] <= '0;
      else if (xfer && sel_we && in_range)    mem[mem_idx]  <= sel_wdata;
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      rr_ptr     <= '0;
      rsp_status <= '0;
      rsp_data   <= '0;
    end else begin
      if (xfer) rr_ptr <= (gnt_idx == PW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
      for (int i = 0; i < NCH; i++) begin
        rsp_status[i*2 +: 2] <= RSP_NONE;
        if (req_ready[i]) begin
          if (!in_range) begin
            rsp_status[i*2 +: 2]  <= RSP_AERR;
            rsp_data[i*DW +: DW]  <= '0;
          end else if (sel_we) begin
            rsp_status[i*2 +: 2]  <= RSP_WACK;
          end else begin
            rsp_status[i*2 +: 2]  <= RSP_READ;
            rsp_data[i*DW +: DW]  <= mem[mem_idx];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ski_mem_ctrl.sv
// tb/tb_ski_mem_ctrl.sv - self-checking bench for ski_mem_ctrl with a cycle model and directed vectors
module tb_ski_mem_ctrl;

  localparam int NCH   = 2;
  localparam int AW    = 30;
  localparam int DW    = 64;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    req_valid, req_we, req_ready;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*DW-1:0] req_wdata, rsp_data;
  logic [NCH*2-1:0]  rsp_status;
  logic              busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ski_mem_ctrl #(
    .NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)
  ) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .rsp_status     (rsp_status),
    .rsp_data       (rsp_data),
    .busy           (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory array, round-robin pointer, expected next-cycle responses
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_valid = 1'b0;
  bit            m_init;
  int            m_k, m_ptr;
  logic [1:0]    e_st   [NCH];
  logic [DW-1:0] e_data [NCH];

  always @(negedge clk) begin
    logic [NCH-1:0] e_rdy;
    logic [AW-1:0]  a;
    int             g;
    e_rdy = '0;
    g     = -1;
    if (!rst && m_valid && !m_init)
      for (int off = 0; off < NCH; off++)
        if (g < 0 && req_valid[(m_ptr + off) % NCH]) g = (m_ptr + off) % NCH;
    if (g >= 0) e_rdy[g] = 1'b1;
    if (m_valid) begin
      chk("model busy", busy, m_init);
      chk("model req_ready", req_ready, e_rdy);
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("model rsp_status[%0d]", i), rsp_status[i*2 +: 2], e_st[i]);
        chk($sformatf("model rsp_data[%0d]", i), rsp_data[i*DW +: DW], e_data[i]);
      end
    end
    if (rst) begin
      m_valid = 1'b1;
      m_init  = 1'b1;
      m_k     = 0;
      m_ptr   = 0;
      for (int i = 0; i < NCH; i++) begin e_st[i] = 2'b00; e_data[i] = '0; end
    end else if (m_valid) begin
      for (int i = 0; i < NCH; i++) e_st[i] = 2'b00;
      if (m_init) begin
        m_mem[m_k] = '0;
        m_k++;
        if (m_k == DEPTH) m_init = 1'b0;
      end else if (g >= 0) begin
        a     = req_addr[g*AW +: AW];
        m_ptr = (g + 1) % NCH;
        if (a >= DEPTH) begin
          e_st[g]   = 2'b11;
          e_data[g] = '0;
        end else if (req_we[g]) begin
          m_mem[a] = req_wdata[g*DW +: DW];
          e_st[g]  = 2'b10;
        end else begin
          e_st[g]   = 2'b01;
          e_data[g] = m_mem[a];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [NCH-1:0] v, input logic [NCH-1:0] we,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_valid = v;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    step();
  endtask

  task automatic idle();
    req_valid = '0;
    step();
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk(name, n, 16);
  endtask

  function automatic logic [1:0] st(input int ch);
    return rsp_status[ch*2 +: 2];
  endfunction

  function automatic logic [DW-1:0] dat(input int ch);
    return rsp_data[ch*DW +: DW];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NCH-1:0] g [4];
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    step(); step();
    chk("reset busy", busy, 1);
    chk("reset rsp_status", rsp_status, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset req_ready", req_ready, 0);
    rst = 1'b0;
    wait_init("init cycles");

    xfer(2'b01, 2'b00, 5, 0, 0, 0);
    chk("rd5 status", st(0), 2'b01);
    chk("rd5 data", dat(0), 0);

    xfer(2'b01, 2'b01, 3, 0, 64'hDEAD_BEEF, 0);
    chk("wr3 status", st(0), 2'b10);
    xfer(2'b01, 2'b00, 3, 0, 0, 0);
    chk("rd3 status", st(0), 2'b01);
    chk("rd3 data", dat(0), 64'hDEAD_BEEF);

    xfer(2'b10, 2'b10, 0, 0, 0, 64'h55);
    chk("ch1 wr0 status", st(1), 2'b10);

    for (int i = 0; i < 4; i++) begin
      req_valid = 2'b11; req_we = 2'b00; req_addr = {AW'(0), AW'(3)};
      #1;
      g[i] = req_ready;
      step();
      chk($sformatf("rr status %0d", i), rsp_status, (i % 2 == 0) ? 4'b0001 : 4'b0100);
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr grant %0d", i), g[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    idle();
    chk("pulse ends", rsp_status, 0);
    chk("hold data0", dat(0), 64'hDEAD_BEEF);
    chk("hold data1", dat(1), 64'h55);

    xfer(2'b10, 2'b00, 0, 16, 0, 0);
    chk("rd16 status", st(1), 2'b11);
    chk("rd16 data", dat(1), 0);
    xfer(2'b10, 2'b10, 0, 16, 0, '1);
    chk("wr16 status", st(1), 2'b11);
    xfer(2'b01, 2'b01, 30'h2000_0003, 0, '1, 0);
    chk("wr high status", st(0), 2'b11);
    xfer(2'b01, 2'b00, 3, 0, 0, 0);
    chk("rd3 unchanged", dat(0), 64'hDEAD_BEEF);
    xfer(2'b10, 2'b00, 0, 0, 0, 0);
    chk("rd0 unchanged", dat(1), 64'h55);

    for (int i = 1; i <= 3; i++) begin
      xfer(2'b01, 2'b01, AW'(i), 0, DW'(i * 10), 0);
      chk($sformatf("preload %0d", i), st(0), 2'b10);
    end
    for (int i = 1; i <= 3; i++) begin
      xfer(2'b01, 2'b00, AW'(i), 0, 0, 0);
      chk($sformatf("b2b status %0d", i), st(0), 2'b01);
      chk($sformatf("b2b data %0d", i), dat(0), DW'(i * 10));
    end

    xfer(2'b01, 2'b01, 15, 0, 64'hABC, 0);
    chk("wr15 status", st(0), 2'b10);
    req_valid = 2'b01; req_we = 2'b00; req_addr = {AW'(0), AW'(15)};
    rst = 1'b1;
    step();
    chk("run reset status", rsp_status, 0);
    chk("run reset data", rsp_data, 0);
    req_valid = '0;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    chk("init reset busy", busy, 1);
    rst = 1'b0;
    wait_init("restart init cycles");

    xfer(2'b01, 2'b01, 4, 0, 64'h77, 0);
    xfer(2'b01, 2'b00, 4, 0, 0, 0);
    chk("rd4 data", dat(0), 64'h77);
    xfer(2'b01, 2'b00, 15, 0, 0, 0);
    chk("rd15 cleared", dat(0), 0);
    xfer(2'b01, 2'b00, 4, 0, 0, 0);
    xfer(2'b01, 2'b00, 3, 0, 0, 0);
    chk("rd3 cleared", dat(0), 0);
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ski_mem_ctrl.md
SKI_MEM_CTRL -- requirements
Module: ski_mem_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 2: number of requester channels, range 1..8.
REQ-002 SHALL have parameter AW, default 30: pointer width.
REQ-003 SHALL have parameter DW, default 64: word width, which is the binarized SKI term.
REQ-004 SHALL have parameter DEPTH, default 1024: number of words stored.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: when 1, the block zero-fills memory after reset.
REQ-006 SHALL have one clock and one reset; the reset is synchronous and active-high.
REQ-007 SHALL have port system1000, input, 1 bit: clock; all state changes on the rising edge.
REQ-008 SHALL have port system1000_rst, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port req_valid, input, NCH bits: per-channel request valid.
REQ-010 SHALL have port req_we, input, NCH bits: per-channel op; 0 = read, 1 = write.
REQ-011 SHALL have port req_addr, input, NCH*AW bits: per-channel pointer; channel i occupies slice [i*AW +: AW].
REQ-012 SHALL have port req_wdata, input, NCH*DW bits: per-channel write data.
REQ-013 SHALL have port req_ready, output, NCH bits: per-channel grant, combinational.
REQ-014 SHALL have port rsp_status, output, NCH*2 bits: per-channel status; 00 = none, 01 = read data, 10 = write ack, 11 = address error.
REQ-015 SHALL have port rsp_data, output, NCH*DW bits: per-channel read data.
REQ-016 SHALL have port busy, output, 1 bit: high while in INIT.

Function
REQ-017 SHALL implement states INIT and RUN; on reset it enters INIT if CLEAR_ON_RESET=1, else RUN.
REQ-018 In INIT, SHALL write 0 to address k in cycle k (k = 0..DEPTH-1), hold req_ready at all zeros, then enter RUN on the cycle after k = DEPTH-1.
REQ-019 In RUN, SHALL grant at most one channel per cycle: req_ready[i]=1 only if req_valid[i]=1 and i is the first valid channel at or after rr_ptr, wrapping modulo NCH.
REQ-020 A request SHALL transfer on the cycle when req_valid[i] and req_ready[i] are both 1.
REQ-021 After a transfer, rr_ptr SHALL become (i+1) mod NCH; with no grant, rr_ptr SHALL hold.
REQ-022 A write with addr < DEPTH SHALL update memory at the clock edge ending the transfer cycle, and rsp_status[i] SHALL be 10 in the next cycle.
REQ-023 A read with addr < DEPTH SHALL give rsp_status[i]=01 and rsp_data[i] = mem[addr] in the next cycle, so latency is exactly 1.
REQ-024 A read transferred in the cycle after a write to the same address SHALL return the new data.
REQ-025 Any request with addr >= DEPTH SHALL leave memory unchanged and give rsp_status[i]=11 with rsp_data[i]=0 in the next cycle.
REQ-026 rsp_status for every channel SHALL be a one-cycle pulse and return to 00 unless a new transfer occurs.
REQ-027 rsp_data[i] SHALL hold its last value until the next read response on channel i.
REQ-028 A throughput of one transfer per cycle SHALL be sustained with no bubbles between back-to-back transfers.
REQ-029 Addresses SHALL be compared at full AW width, with no truncation before the range check.
REQ-030 A requester holding req_valid without a grant SHALL keep its request pending, with no drop and no timeout; fairness SHALL bound the wait to NCH-1 cycles.

Reset
REQ-031 Reset SHALL set rr_ptr=0, all rsp_status=00, all rsp_data=0, req_ready=0, and busy = CLEAR_ON_RESET.
REQ-032 Reset asserted mid-INIT or mid-RUN SHALL abort the current activity, discard in-flight responses, and restart per REQ-017.
REQ-033 With CLEAR_ON_RESET=0, memory contents SHALL be undefined after reset.

Structure
REQ-034 The status encodings (00/01/10/11), the state enum (INIT, RUN), and the default parameter values SHALL live in the shared ski_mem_pkg package.
REQ-035 The round-robin arbiter SHALL be a single sub-module, ski_rr_arbiter, parametrised by NCH: inputs req and ptr; outputs grant (one-hot) and idx.

Verification
REQ-036 With NCH=2, DEPTH=16, CLEAR_ON_RESET=1: reset, then read addr 5 on channel 0 → busy high for exactly 16 cycles, then status 01 with data 0.
REQ-037 Channel 0 writes 64'hDEAD_BEEF to addr 3, and channel 0 reads addr 3 in the next cycle → status 10, then status 01 with data 64'hDEAD_BEEF.
REQ-038 Both channels hold req_valid for 4 cycles with rr_ptr=0 → grants go 0,1,0,1, and each status pulses once per grant.
REQ-039 Channel 1 reads addr 16 with DEPTH=16 → status 11 with data 0, and memory is unchanged.
REQ-040 Reset is asserted at INIT cycle 7 → busy stays high, and zero-fill restarts at address 0 for 16 further cycles.
REQ-041 Back-to-back reads on channel 0 of addrs 1, 2, 3 preloaded with 10, 20, 30 → data 10, 20, 30 in consecutive cycles with no gaps.
